hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
//  A 3-slot scoreboard tracks in-flight destination registers. The block holds PC and IF/ID
//  and injects an EX bubble on RAW hazards. It flushes younger stages on a taken branch
//  (resolved in MEM) or a jump (resolved in ID). Programs then no longer need hand-padded NOPs.

---
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: a 3-slot destination scoreboard drives RAW stalls,
// and jumps (ID) or taken branches (MEM) flush the younger pipeline stages.
module hazard_ctrl #(
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wd,
  input  logic             id_is_load,
  input  logic             id_jump,
  input  logic             mem_br_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             flush_exmem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hit_rs;
  logic hit_rt;
  logic stall_raw;
  logic stall_eff;
  logic jump_acc;

  function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
    return s.v && (s.rd == r) && (r != 5'd0);
  endfunction

  // With forwarding only a load sitting in EX is unresolvable; without it,
  // the register file has no write-through so WB must also be checked.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    if (FWD_EN != 0) begin
      hit_rs = slot_hit(ex_q, id_rs) && ex_q.ld;
      hit_rt = slot_hit(ex_q, id_rt) && ex_q.ld;
    end else begin
      hit_rs = slot_hit(ex_q, id_rs) || slot_hit(mem_q, id_rs) || slot_hit(wb_q, id_rs);
      hit_rt = slot_hit(ex_q, id_rt) || slot_hit(mem_q, id_rt) || slot_hit(wb_q, id_rt);
    end
  end

  always_comb begin
    stall_raw = id_valid && ((id_use_rs && hit_rs) || (id_use_rt && hit_rt));
    stall_eff = stall_raw && !mem_br_taken;
    jump_acc  = id_jump && !stall_raw && !mem_br_taken;
  end

  always_comb begin
    pc_hold     = !rst && stall_eff;
    ifid_hold   = !rst && stall_eff;
    idex_bubble = !rst && (stall_raw || mem_br_taken);
    flush_ifid  = !rst && (mem_br_taken || (id_jump && !stall_raw));
    flush_exmem = !rst && mem_br_taken;
  end

  // The instruction in EX is younger than a branch resolving in MEM, so its
  // slot dies on the way into MEM; MEM and WB entries are older and survive.
  always_comb begin
    ex_d.v  = id_valid && id_wr_en && (id_wd != 5'd0) && !stall_raw && !mem_br_taken;
    ex_d.rd = id_wd;
    ex_d.ld = id_is_load;
    mem_d   = ex_q;
    if (mem_br_taken) begin
      mem_d.v = 1'b0;
    end
    wb_d = mem_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_eff && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if ((mem_br_taken || jump_acc) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (no forwarding, forwarding,
// 2-bit counters) share one stimulus stream and are reset before each scenario.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_jump, mem_br_taken;
  logic [4:0] id_rs, id_rt, id_wd;

  logic pc_hold0, ifid_hold0, idex_bubble0, flush_ifid0, flush_exmem0;
  logic pc_hold1, ifid_hold1, idex_bubble1, flush_ifid1, flush_exmem1;
  logic pc_hold2, ifid_hold2, idex_bubble2, flush_ifid2, flush_exmem2;
  logic [31:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // control bit order: pc_hold, ifid_hold, idex_bubble, flush_ifid, flush_exmem
  wire [31:0] ctl0 = {27'd0, pc_hold0, ifid_hold0, idex_bubble0, flush_ifid0, flush_exmem0};
  wire [31:0] ctl1 = {27'd0, pc_hold1, ifid_hold1, idex_bubble1, flush_ifid1, flush_exmem1};
  wire [31:0] ctl2 = {27'd0, pc_hold2, ifid_hold2, idex_bubble2, flush_ifid2, flush_exmem2};
  wire [31:0] sc2  = {30'd0, stall_cnt2};

  localparam logic [31:0] C_NONE  = 32'b00000;
  localparam logic [31:0] C_STALL = 32'b11100;
  localparam logic [31:0] C_BR    = 32'b00111;
  localparam logic [31:0] C_JUMP  = 32'b00010;

  hazard_ctrl #(.FWD_EN(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wd(id_wd),
    .id_is_load(id_is_load), .id_jump(id_jump), .mem_br_taken(mem_br_taken),
    .pc_hold(pc_hold0), .ifid_hold(ifid_hold0), .idex_bubble(idex_bubble0),
    .flush_ifid(flush_ifid0), .flush_exmem(flush_exmem0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wd(id_wd),
    .id_is_load(id_is_load), .id_jump(id_jump), .mem_br_taken(mem_br_taken),
    .pc_hold(pc_hold1), .ifid_hold(ifid_hold1), .idex_bubble(idex_bubble1),
    .flush_ifid(flush_ifid1), .flush_exmem(flush_exmem1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  hazard_ctrl #(.FWD_EN(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wd(id_wd),
    .id_is_load(id_is_load), .id_jump(id_jump), .mem_br_taken(mem_br_taken),
    .pc_hold(pc_hold2), .ifid_hold(ifid_hold2), .idex_bubble(idex_bubble2),
    .flush_ifid(flush_ifid2), .flush_exmem(flush_exmem2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one ID/MEM input vector at the falling edge; checks follow 1 ns later.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic we, input logic [4:0] wd,
                     input logic ld, input logic jmp, input logic br);
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wr_en = we; id_wd = wd; id_is_load = ld; id_jump = jmp; mem_br_taken = br;
    #1;
  endtask

  task automatic rst_all();
    @(negedge clk);
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wr_en = 0; id_wd = 0; id_is_load = 0; id_jump = 0; mem_br_taken = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst_all();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset ctl0", ctl0, C_NONE);
    chk("reset ctl1", ctl1, C_NONE);
    chk("reset stall_cnt0", stall_cnt0, 32'd0);
    chk("reset flush_cnt0", flush_cnt0, 32'd0);

    // add r5 <= r0+r4 ; add r7 <= r5+r6 without forwarding: 3 stall cycles
    rst_all();
    cyc(1, 0, 4, 1, 1, 1, 5, 0, 0, 0);
    chk("raw producer ctl0", ctl0, C_NONE);
    cyc(1, 5, 6, 1, 1, 1, 7, 0, 0, 0);
    chk("raw stall1 ctl0", ctl0, C_STALL);
    chk("raw fwd alu no stall ctl1", ctl1, C_NONE);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 5, 6, 1, 1, 1, 7, 0, 0, 0);
      chk("raw stall2-3 ctl0", ctl0, C_STALL);
    end
    cyc(1, 5, 6, 1, 1, 1, 7, 0, 0, 0);
    chk("raw release ctl0", ctl0, C_NONE);
    chk("raw stall_cnt0", stall_cnt0, 32'd3);

    // forwarding: lw r1 ; beq r1,r6 -> one stall ; add r1 ; add r2 reads r1 -> none
    rst_all();
    cyc(1, 2, 0, 1, 0, 1, 1, 1, 0, 0);
    chk("lw ctl1", ctl1, C_NONE);
    cyc(1, 1, 6, 1, 1, 0, 0, 0, 0, 0);
    chk("load-use stall ctl1", ctl1, C_STALL);
    cyc(1, 1, 6, 1, 1, 0, 0, 0, 0, 0);
    chk("load-use release ctl1", ctl1, C_NONE);
    chk("load-use stall_cnt1", stall_cnt1, 32'd1);
    cyc(1, 3, 0, 1, 0, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 1, 2, 0, 0, 0);
    chk("alu-alu fwd ctl1", ctl1, C_NONE);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd stall_cnt1 final", stall_cnt1, 32'd1);

    // taken branch overrides a stall and kills the younger writers
    rst_all();
    cyc(1, 1, 2, 1, 1, 1, 8, 0, 0, 0);
    cyc(1, 8, 0, 1, 0, 1, 9, 0, 0, 1);
    chk("branch over stall ctl0", ctl0, C_BR);
    cyc(1, 8, 9, 1, 1, 1, 10, 0, 0, 0);
    chk("killed writers ctl0", ctl0, C_NONE);
    chk("branch flush_cnt0", flush_cnt0, 32'd1);
    chk("branch stall_cnt0", stall_cnt0, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("branch over jump ctl0", ctl0, C_BR);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("branch+jump one event", flush_cnt0, 32'd2);

    // jump with no hazard, then a jump that must wait behind a stall
    rst_all();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("jump ctl0", ctl0, C_JUMP);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("jump one cycle ctl0", ctl0, C_NONE);
    chk("jump flush_cnt0", flush_cnt0, 32'd1);
    cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    cyc(1, 3, 0, 1, 0, 0, 0, 0, 1, 0);
    chk("stall over jump ctl0", ctl0, C_STALL);
    cyc(1, 3, 0, 1, 0, 0, 0, 0, 1, 0);
    chk("held jump flush_cnt0", flush_cnt0, 32'd1);

    // r0 is never tracked; invalid or non-reading ID never stalls
    rst_all();
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("r0 read ctl0", ctl0, C_NONE);
    cyc(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    cyc(0, 10, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("invalid id ctl0", ctl0, C_NONE);
    cyc(1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rs unused ctl0", ctl0, C_NONE);
    cyc(1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("wb slot hit ctl0", ctl0, C_STALL);

    // reset in the middle of a stall clears scoreboard and counters
    rst_all();
    cyc(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
    cyc(1, 11, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("pre-reset stall ctl0", ctl0, C_STALL);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset ctl0", ctl0, C_NONE);
    chk("post-reset stall_cnt0", stall_cnt0, 32'd0);
    chk("post-reset flush_cnt0", flush_cnt0, 32'd0);

    // 2-bit counters saturate at 3 after 5 stall cycles
    rst_all();
    cyc(1, 0, 0, 0, 0, 1, 12, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 12, 0, 1, 0, 1, 13, 0, 0, 0);
      chk("sat stall A ctl2", ctl2, C_STALL);
    end
    cyc(1, 12, 0, 1, 0, 1, 13, 0, 0, 0);
    chk("sat release ctl2", ctl2, C_NONE);
    chk("sat cnt at 3", sc2, 32'd3);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 13, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("sat stall B ctl2", ctl2, C_STALL);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat cnt holds", sc2, 32'd3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
